// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch grant when data hogs the port.
module mem_port_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_done,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        stall
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned STK_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [STK_W-1:0] streak;
  logic             elig_i;
  logic             elig_d;
  logic             grant_i;
  logic             grant_d;
  logic             last_beat;
  logic             mem_we_nxt;
  logic             mem_re_nxt;
  logic             if_done_nxt;
  logic             d_done_nxt;

  // A port is not re-granted in the cycle its done pulse is visible.
  always_comb begin
    elig_i    = if_req & ~if_done;
    elig_d    = d_req & ~d_done;
    last_beat = (cnt == CNT_W'(LATENCY - 1));
  end

  assign stall = (if_req & ~if_done) | (d_req & ~d_done);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (elig_d && (!elig_i || (streak < STK_W'(STARVE_MAX)))) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (elig_i) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered: raised on grant, dropped after the final busy beat.
  always_comb begin
    mem_we_nxt  = 1'b0;
    mem_re_nxt  = 1'b0;
    if_done_nxt = 1'b0;
    d_done_nxt  = 1'b0;
    if (grant_i) begin
      mem_re_nxt = 1'b1;
    end else if (grant_d) begin
      mem_we_nxt = d_we;
      mem_re_nxt = ~d_we;
    end else if ((state != IDLE) && !last_beat) begin
      mem_we_nxt = mem_we;
      mem_re_nxt = mem_re;
    end
    if ((state == BUSY_I) && last_beat) if_done_nxt = 1'b1;
    if ((state == BUSY_D) && last_beat) d_done_nxt  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      streak    <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_done <= if_done_nxt;
      d_done  <= d_done_nxt;
      mem_we  <= mem_we_nxt;
      mem_re  <= mem_re_nxt;

      if (state == IDLE) cnt <= '0;
      else               cnt <= cnt + CNT_W'(1);

      if (grant_i) begin
        mem_addr <= if_addr;
      end else if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end

      // Streak only counts data grants that made a waiting fetch wait longer.
      if (grant_i) begin
        streak <= '0;
      end else if (grant_d && elig_i && (streak < STK_W'(STARVE_MAX))) begin
        streak <= streak + STK_W'(1);
      end

      if ((state == BUSY_I) && last_beat) begin
        if_rdata <= mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
      end
      if ((state == BUSY_D) && last_beat && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level model predicts
// completion cycles and data; a monitor compares them as the DUT produces them.
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_done;
  logic [63:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall;

  mem_port_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] pat(input logic [63:0] k);
    return {k[31:0] ^ 32'h5A5A_0000, ~k[31:0]};
  endfunction

  // Memory device: real data only on the final read beat, junk otherwise.
  logic [63:0] phys [logic [63:0]];
  int rcnt = 0;
  always @(negedge clk) begin
    if (mem_we) phys[mem_addr >> 3] = mem_wdata;
    rcnt = mem_re ? rcnt + 1 : 0;
    if (mem_re && (rcnt == int'(LAT)))
      mem_rdata = phys.exists(mem_addr >> 3) ? phys[mem_addr >> 3] : pat(mem_addr >> 3);
    else
      mem_rdata = {$urandom, $urandom};
  end

  // Reference model: serialised accesses, each owning the port for LAT cycles.
  typedef struct packed {
    int          at;
    logic [63:0] data;
  } exp_t;

  exp_t        qi[$];
  exp_t        qd[$];
  logic [63:0] ref_mem [logic [63:0]];
  bit          model_ok  = 1'b0;
  int          free_at   = 0;
  int          di_at     = -1;
  int          dd_at     = -1;
  int          g_at      = -1;
  bit          g_data    = 1'b0;
  bit          g_we      = 1'b0;
  logic [63:0] g_addr    = '0;
  logic [63:0] g_wdata   = '0;
  logic [63:0] last_load = '0;
  int          streak    = 0;
  bit          x_busy    = 1'b0;
  bit          x_re      = 1'b0;
  bit          x_we      = 1'b0;
  bit          x_idone   = 1'b0;
  bit          x_ddone   = 1'b0;

  function automatic logic [63:0] ref_rd(input logic [63:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : pat(k);
  endfunction

  always @(posedge clk) begin : model
    int          c;
    int          n;
    bit          ei;
    bit          ed;
    logic [63:0] v;
    c = cyc;
    if (reset) begin
      qi.delete();
      qd.delete();
      streak    = 0;
      free_at   = c + 1;
      di_at     = -1;
      dd_at     = -1;
      g_at      = -1;
      last_load = '0;
      model_ok  = 1'b1;
    end else if (model_ok && (c >= free_at)) begin
      ei = if_req && (c != di_at);
      ed = d_req && (c != dd_at);
      if (ed && (!ei || (streak < int'(SMAX)))) begin
        g_at = c; g_data = 1'b1; g_we = d_we; g_addr = d_addr; g_wdata = d_wdata;
        if (d_we) begin
          ref_mem[d_addr >> 3] = d_wdata;
        end else begin
          last_load = ref_rd(d_addr >> 3);
        end
        qd.push_back('{at: c + int'(LAT) + 1, data: last_load});
        dd_at   = c + int'(LAT) + 1;
        free_at = dd_at;
        if (ei && (streak < int'(SMAX))) streak++;
      end else if (ei) begin
        g_at = c; g_data = 1'b0; g_we = 1'b0; g_addr = if_addr;
        v = ref_rd(if_addr >> 3);
        qi.push_back('{at: c + int'(LAT) + 1,
                       data: {32'h0, (if_addr[2] ? v[63:32] : v[31:0])}});
        di_at   = c + int'(LAT) + 1;
        free_at = di_at;
        streak  = 0;
      end
    end
    n       = c + 1;
    x_busy  = (g_at >= 0) && (n >= g_at + 1) && (n <= g_at + int'(LAT));
    x_re    = x_busy && !(g_data && g_we);
    x_we    = x_busy && g_data && g_we;
    x_idone = (n == di_at);
    x_ddone = (n == dd_at);
  end

  // Monitor: pop expectations when the DUT signals completion; check strobes each cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (model_ok) begin
      if (if_done) begin
        if (qi.size() == 0) chk("if_done_unexpected", 64'(if_done), 64'(0));
        else begin
          e = qi.pop_front();
          chk("if_done_cycle", 64'(cyc), 64'(e.at));
          chk("if_rdata", 64'(if_rdata), e.data);
        end
      end else if ((qi.size() > 0) && (qi[0].at <= cyc)) begin
        e = qi.pop_front();
        chk("if_done_missing", 64'(if_done), 64'(1));
      end
      if (d_done) begin
        if (qd.size() == 0) chk("d_done_unexpected", 64'(d_done), 64'(0));
        else begin
          e = qd.pop_front();
          chk("d_done_cycle", 64'(cyc), 64'(e.at));
          chk("d_rdata", d_rdata, e.data);
        end
      end else if ((qd.size() > 0) && (qd[0].at <= cyc)) begin
        e = qd.pop_front();
        chk("d_done_missing", 64'(d_done), 64'(1));
      end
      chk("stall", 64'(stall), 64'((if_req && !x_idone) || (d_req && !x_ddone)));
      chk("mem_re", 64'(mem_re), 64'(x_re));
      chk("mem_we", 64'(mem_we), 64'(x_we));
      if (x_busy) chk("mem_addr", mem_addr, g_addr);
      if (x_we)   chk("mem_wdata", mem_wdata, g_wdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input bit dp);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1;
      if (dp ? d_done : if_done) return;
    end
    n_chk++;
    $display("FAIL %s_timeout: got no done within 64 cycles, required one (cycle %0d)",
             dp ? "d" : "if", cyc);
  endtask

  task automatic fetch_op(input logic [63:0] a);
    if_addr = a;
    if_req  = 1'b1;
    wait_done(1'b0);
    if_req  = 1'b0;
  endtask

  task automatic data_op(input logic we, input logic [63:0] a, input logic [63:0] wd);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    wait_done(1'b1);
    d_req   = 1'b0;
  endtask

  task automatic port_loop(input bit dp, input int n);
    int gap;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        if (dp) d_req = 1'b0;
        else    if_req = 1'b0;
        idle(gap);
      end
      if (dp) begin
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 64'($urandom_range(0, 15)) << 3;
        d_wdata = {$urandom, $urandom};
        d_req   = 1'b1;
      end else begin
        if_addr = 64'($urandom_range(0, 31)) << 2;
        if_req  = 1'b1;
      end
      wait_done(dp);
    end
    if (dp) d_req = 1'b0;
    else    if_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    phys[64'd1]    = 64'h1111_2222_3333_4444;
    ref_mem[64'd1] = 64'h1111_2222_3333_4444;
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 64'h8;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 64'h20;
    d_wdata = '0;

    // Outputs cleared after the first reset edge while both requests are held.
    @(posedge clk);
    @(negedge clk);
    chk("rst_if_done", 64'(if_done), 64'(0));
    chk("rst_d_done", 64'(d_done), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_re", 64'(mem_re), 64'(0));
    chk("rst_if_rdata", 64'(if_rdata), 64'(0));
    chk("rst_d_rdata", d_rdata, 64'(0));
    chk("rst_mem_addr", mem_addr, 64'(0));
    chk("rst_mem_wdata", mem_wdata, 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Simultaneous fetch and data read: data first, then fetch.
    fork
      begin wait_done(1'b0); if_req = 1'b0; end
      begin wait_done(1'b1); d_req  = 1'b0; end
    join
    idle(2);

    fetch_op(64'h8);
    idle(1);
    fetch_op(64'hC);
    idle(1);
    data_op(1'b0, 64'h8, '0);
    idle(1);
    data_op(1'b1, 64'h10, 64'hDEAD);
    idle(1);
    data_op(1'b0, 64'h10, '0);
    idle(1);

    // Both ports held back to back.
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          if_addr = 64'(k) << 2;
          if_req  = 1'b1;
          wait_done(1'b0);
        end
        if_req = 1'b0;
      end
      begin
        for (int k = 0; k < 5; k++) begin
          d_we   = 1'b0;
          d_addr = 64'(k) << 3;
          d_req  = 1'b1;
          wait_done(1'b1);
        end
        d_req = 1'b0;
      end
    join
    idle(2);

    // Reset in the first busy cycle of a write aborts it; the held request is re-granted.
    d_we    = 1'b1;
    d_addr  = 64'h18;
    d_wdata = 64'hBEEF;
    d_req   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_mem_we", 64'(mem_we), 64'(0));
    chk("abort_mem_re", 64'(mem_re), 64'(0));
    chk("abort_d_done", 64'(d_done), 64'(0));
    reset = 1'b0;
    wait_done(1'b1);
    d_req = 1'b0;
    idle(1);
    data_op(1'b0, 64'h18, '0);
    idle(2);

    fork
      port_loop(1'b0, 150);
      port_loop(1'b1, 150);
    join
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
